vscpu_run_ctrl: RTL and testbench

//  Run controller and RAM-port owner for the SimpleCPU core. Muxes the single RAM port between a host

---
 rtl/vscpu_run_ctrl_pkg.sv | 23 ++
 rtl/vscpu_run_ctrl_if.sv | 32 +++
 rtl/vscpu_run_ctrl_halt_det.sv | 49 ++++
 rtl/vscpu_run_ctrl.sv | 145 ++++++++++++++
 tb/tb_vscpu_run_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vscpu_run_ctrl_pkg.sv
// Shared definitions for the SimpleCPU run controller.
//   - Default RAM address/data widths (ADDR_W = CPU SIZE).
//   - Run-state encoding used by the controller FSM and exposed on its
//     debug port.
//   - Small decode helper for the "CPU is being driven" states.
package vscpu_run_ctrl_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_RST_CPU = 2'd1;
  localparam logic [ST_W-1:0] ST_RUN     = 2'd2;
  localparam logic [ST_W-1:0] ST_STOP    = 2'd3;

  // True in the states where a run is in progress (CPU being reset or executing).
  function automatic logic state_is_busy(input logic [ST_W-1:0] st);
    return (st == ST_RST_CPU) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/vscpu_run_ctrl_if.sv
// Host load/dump port of the run controller.
//   master : host side (drives request, write enable, address, write data)
//   slave  : controller side (drives ready, read-valid, read data)
//
// Handshake: a request transfers in every cycle where host_req and
// host_ready are both high. host_ready is combinational from host_req and
// may stay low for many cycles; the host must hold host_req, host_we,
// host_addr and host_wdata stable until it sees host_ready. An accepted
// read returns host_rvalid=1 with host_rdata exactly one cycle later;
// there is no back-pressure on the read return.
interface vscpu_run_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) ();
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/vscpu_run_ctrl_halt_det.sv
// Halt detector: flags a program that has parked itself in a self-loop.
// A SimpleCPU instruction takes at most 5 cycles, so an unchanged PC over
// HALT_WIN consecutive compares means the program is spinning on one
// instruction.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clr       clears history (asserted the cycle before a run starts)
//   en        compare enable (high while the CPU is running)
//   pc        current CPU program counter
//   halt      combinational: this cycle completes HALT_WIN equal compares
module vscpu_run_ctrl_halt_det #(
  parameter int ADDR_W   = 14,
  parameter int HALT_WIN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  output logic              halt
);
  localparam int CNT_W = $clog2(HALT_WIN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_WIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALT_WIN);

  logic [ADDR_W-1:0] prev_pc;
  logic              prev_vld;  // first enabled cycle has nothing to compare against
  logic [CNT_W-1:0]  same_cnt;
  logic              same;

  assign same = prev_vld && (pc == prev_pc);
  assign halt = en && same && (same_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
      same_cnt <= '0;
    end else if (en) begin
      prev_pc  <= pc;
      prev_vld <= 1'b1;
      if (!same) begin
        same_cnt <= '0;
      end else if (same_cnt != CNT_MAX) begin
        same_cnt <= same_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vscpu_run_ctrl.sv
// Run controller and RAM-port owner for the SimpleCPU core.
// Muxes the single RAM port between the host load/dump interface and the
// CPU, sequences cpu_rst to start/stop execution, ends a run on halt
// (self-loop), cycle-budget timeout or abort, and reports cycle count and
// final PC.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   host                host RAM access port (slave side)
//   start, abort        run control pulses
//   busy                high while the CPU is being reset or running
//   done, timeout       sticky run-end flags, cleared by start
//   cycles              RUN cycles in current/last run
//   final_pc            CPU PC captured at run end
//   cpu_rst             reset to the CPU core
//   cpu_wrEn/addr/wdata CPU RAM request, cpu_pc CPU program counter
//   cpu_rdata           RAM read data to the CPU
//   ram_we/addr/wdata   RAM port (sync read, ram_rdata one cycle later)
//   dbg_state           current run state
module vscpu_run_ctrl
  import vscpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int HALT_WIN   = 16,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  vscpu_run_ctrl_if.slave   host,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycles,
  output logic [ADDR_W-1:0] final_pc,
  output logic              cpu_rst,
  input  logic              cpu_wrEn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ST_W-1:0]   dbg_state
);
  localparam logic [31:0] MAX_C = 32'(MAX_CYCLES);

  logic [ST_W-1:0] state;
  logic            host_acc;
  logic            rd_pend;
  logic [31:0]     cyc_next;
  logic            hit_max;
  logic            halt;

  // start has priority over a host request arriving in the same cycle.
  assign host_acc         = host.host_req && (state == ST_IDLE) && !start;
  assign host.host_ready  = host_acc;
  assign host.host_rvalid = rd_pend;
  // RAM read latency is one cycle, so the data lines up with rd_pend.
  assign host.host_rdata  = rd_pend ? ram_rdata : '0;

  assign busy      = state_is_busy(state);
  assign cpu_rst   = (state != ST_RUN);
  assign cpu_rdata = ram_rdata;
  assign dbg_state = state;

  assign cyc_next = cycles + 32'd1;
  assign hit_max  = (cyc_next == MAX_C);

  vscpu_run_ctrl_halt_det #(
    .ADDR_W   (ADDR_W),
    .HALT_WIN (HALT_WIN)
  ) u_halt_det (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_RST_CPU),
    .en   (state == ST_RUN),
    .pc   (cpu_pc),
    .halt (halt)
  );

  // RAM port: CPU owns it while running; otherwise only an accepted host
  // request reaches it, and an idle port is parked at zero.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == ST_RUN) begin
      ram_we    = cpu_wrEn;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (host_acc) begin
      ram_we    = host.host_we;
      ram_addr  = host.host_addr;
      ram_wdata = host.host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      timeout  <= 1'b0;
      cycles   <= '0;
      final_pc <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= host_acc && !host.host_we;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RST_CPU;
            done    <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
          end
        end
        ST_RST_CPU: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          cycles <= cyc_next;
          // abort > timeout > halt when they coincide
          if (abort) begin
            state <= ST_STOP;
          end else if (hit_max) begin
            timeout <= 1'b1;
            state   <= ST_STOP;
          end else if (halt) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          final_pc <= cpu_pc;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vscpu_run_ctrl.sv
// Testbench for vscpu_run_ctrl: host RAM access, halt, timeout, abort,
// host stalling and mid-run reset, with randomized PC traces and CPU
// traffic predicted by a trace-level run model.
module tb_vscpu_run_ctrl;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int HALT_WIN   = 16;
  localparam int MAX_CYCLES = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  vscpu_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hif ();
  logic              start, abort, busy, done, timeout, cpu_rst, cpu_wrEn, ram_we;
  logic [31:0]       cycles;
  logic [ADDR_W-1:0] final_pc, cpu_addr, cpu_pc, ram_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic [1:0]        dbg_state;

  vscpu_run_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_WIN(HALT_WIN), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .host(hif.slave), .start(start), .abort(abort),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles), .final_pc(final_pc),
    .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_pc(cpu_pc), .cpu_rdata(cpu_rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // Environment RAM: synchronous read, one-cycle latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- reference model state ----------------
  int                n_cmp = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] ref_mem [0:15];
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] pcs[$];

  // Outcome of a run from the PC trace: run ends on the first RUN cycle
  // where abort is seen, the budget is reached, or the PC has been the
  // same for HALT_WIN+1 consecutive cycles (checked in that priority).
  function automatic void predict(input int abort_at, output int k, output bit to);
    bit flat;
    k  = MAX_CYCLES;
    to = 1'b1;
    for (int i = 0; i < MAX_CYCLES; i++) begin
      if (i == abort_at) begin k = i + 1; to = 1'b0; return; end
      if (i + 1 == MAX_CYCLES) begin k = i + 1; to = 1'b1; return; end
      if (i >= HALT_WIN) begin
        flat = 1'b1;
        for (int j = i - HALT_WIN; j < i; j++) if (pcs[j] != pcs[i]) flat = 1'b0;
        if (flat) begin k = i + 1; to = 1'b0; return; end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic [3:0] a, input logic [DATA_W-1:0] d);
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = ADDR_W'(a); hif.host_wdata = d;
    @(negedge clk);
    n_cmp++; if (hif.host_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b exp 1", hif.host_ready); end
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL wr_ram_we: got %b exp 1", ram_we); end
    n_cmp++; if (ram_addr !== ADDR_W'(a)) begin n_err++; $display("FAIL wr_ram_addr: got %h exp %h", ram_addr, a); end
    n_cmp++; if (ram_wdata !== d) begin n_err++; $display("FAIL wr_ram_wdata: got %h exp %h", ram_wdata, d); end
    ref_mem[a] = d;
    @(posedge clk); #1;
    hif.host_req = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a);
    logic [DATA_W-1:0] e;
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = ADDR_W'(a);
    @(negedge clk);
    n_cmp++; if (hif.host_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %b exp 1", hif.host_ready); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rd_ram_we: got %b exp 0", ram_we); end
    exp_q.push_back(ref_mem[a]);
    @(posedge clk); #1;
    hif.host_req = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if (hif.host_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b exp 1", hif.host_rvalid); end
    n_cmp++; if (hif.host_rdata !== e) begin n_err++; $display("FAIL rd_rdata addr %0d: got %h exp %h", a, hif.host_rdata, e); end
    @(posedge clk); #1;
  endtask

  // One full run over the current pcs trace, checked cycle by cycle.
  task automatic do_run(input int abort_at, input bit hold_req, input bit start_noise);
    int k;
    bit to;
    logic [3:0] ha;
    logic [DATA_W-1:0] hd;
    predict(abort_at, k, to);
    ha = 4'($urandom_range(0, 15));
    hd = $urandom;
    start = 1'b1;
    if (hold_req) begin
      hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = ADDR_W'(ha); hif.host_wdata = hd;
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b exp 0", busy); end
    if (hold_req) begin
      n_cmp++; if (hif.host_ready !== 1'b0) begin n_err++; $display("FAIL start_beats_host: got %b exp 0", hif.host_ready); end
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstcpu_busy: got %b exp 1", busy); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL rstcpu_cpu_rst: got %b exp 1", cpu_rst); end
    if (hold_req) begin
      n_cmp++; if (hif.host_ready !== 1'b0) begin n_err++; $display("FAIL rstcpu_stall: got %b exp 0", hif.host_ready); end
    end
    @(posedge clk); #1;
    for (int i = 0; i < k; i++) begin
      cpu_pc    = pcs[i];
      cpu_wrEn  = 1'($urandom_range(0, 1));
      cpu_addr  = ADDR_W'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      abort     = (i == abort_at);
      start     = start_noise & 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++; if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL run_cpu_rst cyc %0d: got %b exp 0", i, cpu_rst); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy cyc %0d: got %b exp 1", i, busy); end
      n_cmp++; if (ram_we !== cpu_wrEn) begin n_err++; $display("FAIL run_ram_we cyc %0d: got %b exp %b", i, ram_we, cpu_wrEn); end
      n_cmp++; if (ram_addr !== cpu_addr) begin n_err++; $display("FAIL run_ram_addr cyc %0d: got %h exp %h", i, ram_addr, cpu_addr); end
      n_cmp++; if (ram_wdata !== cpu_wdata) begin n_err++; $display("FAIL run_ram_wdata cyc %0d: got %h exp %h", i, ram_wdata, cpu_wdata); end
      n_cmp++; if (cpu_rdata !== ram_rdata) begin n_err++; $display("FAIL run_cpu_rdata cyc %0d: got %h exp %h", i, cpu_rdata, ram_rdata); end
      if (hold_req) begin
        n_cmp++; if (hif.host_ready !== 1'b0) begin n_err++; $display("FAIL run_stall cyc %0d: got %b exp 0", i, hif.host_ready); end
      end
      if (cpu_wrEn) ref_mem[cpu_addr[3:0]] = cpu_wdata;
      @(posedge clk); #1;
    end
    abort    = 1'b0;
    cpu_wrEn = 1'b0;
    start    = start_noise;
    @(negedge clk);
    n_cmp++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL stop_cpu_rst: got %b exp 1", cpu_rst); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stop_done: got %b exp 0", done); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL stop_ram_we: got %b exp 0", ram_we); end
    if (hold_req) begin
      n_cmp++; if (hif.host_ready !== 1'b0) begin n_err++; $display("FAIL stop_stall: got %b exp 0", hif.host_ready); end
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL end_done: got %b exp 1", done); end
    n_cmp++; if (timeout !== to) begin n_err++; $display("FAIL end_timeout: got %b exp %b", timeout, to); end
    n_cmp++; if (cycles !== 32'(k)) begin n_err++; $display("FAIL end_cycles: got %0d exp %0d", cycles, k); end
    n_cmp++; if (final_pc !== pcs[k-1]) begin n_err++; $display("FAIL end_final_pc: got %h exp %h", final_pc, pcs[k-1]); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL end_cpu_rst: got %b exp 1", cpu_rst); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL end_busy: got %b exp 0", busy); end
    if (hold_req) begin
      n_cmp++; if (hif.host_ready !== 1'b1) begin n_err++; $display("FAIL idle_accept: got %b exp 1", hif.host_ready); end
      n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL idle_accept_we: got %b exp 1", ram_we); end
      n_cmp++; if (ram_addr !== ADDR_W'(ha)) begin n_err++; $display("FAIL idle_accept_addr: got %h exp %h", ram_addr, ha); end
      ref_mem[ha] = hd;
    end
    @(posedge clk); #1;
    hif.host_req = 1'b0;
  endtask

  task automatic gen_random_pcs();
    logic [ADDR_W-1:0] p;
    int len;
    pcs.delete();
    while (pcs.size() < MAX_CYCLES) begin
      p   = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      len = $urandom_range(1, HALT_WIN + 6);
      for (int j = 0; j < len; j++) pcs.push_back(p);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL rst_cpu_rst: got %b exp 1", cpu_rst); end
    n_cmp++; if (hif.host_ready !== 1'b0) begin n_err++; $display("FAIL rst_host_ready: got %b exp 0", hif.host_ready); end
    n_cmp++; if (hif.host_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_host_rvalid: got %b exp 0", hif.host_rvalid); end
    n_cmp++; if (hif.host_rdata !== '0) begin n_err++; $display("FAIL rst_host_rdata: got %h exp 0", hif.host_rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b exp 0", done); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b exp 0", timeout); end
    n_cmp++; if (cycles !== 32'd0) begin n_err++; $display("FAIL rst_cycles: got %0d exp 0", cycles); end
    n_cmp++; if (final_pc !== '0) begin n_err++; $display("FAIL rst_final_pc: got %h exp 0", final_pc); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %b exp 0", ram_we); end
    n_cmp++; if (ram_addr !== '0) begin n_err++; $display("FAIL rst_ram_addr: got %h exp 0", ram_addr); end
    n_cmp++; if (ram_wdata !== '0) begin n_err++; $display("FAIL rst_ram_wdata: got %h exp 0", ram_wdata); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_host_rw();
    host_write(4'd0, 32'h9000_4005);
    @(negedge clk);
    n_cmp++; if (hif.host_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b exp 0", hif.host_rvalid); end
    @(posedge clk); #1;
    host_read(4'd0);
    for (int a = 1; a < 16; a++) host_write(4'(a), $urandom);
    for (int n = 0; n < 8; n++) host_read(4'($urandom_range(0, 15)));
  endtask

  task automatic test_halt_loop();
    pcs.delete();
    for (int i = 0; i < MAX_CYCLES; i++) pcs.push_back(ADDR_W'(i < 3 ? i : 3));
    do_run(-1, 1'b0, 1'b0);
    for (int a = 0; a < 16; a += 3) host_read(4'(a));
  endtask

  task automatic test_timeout();
    pcs.delete();
    for (int i = 0; i < MAX_CYCLES; i++) pcs.push_back(ADDR_W'(i % 2));
    do_run(-1, 1'b0, 1'b0);
  endtask

  task automatic test_abort_with_halt();
    pcs.delete();
    for (int i = 0; i < MAX_CYCLES; i++) pcs.push_back(ADDR_W'(i < 3 ? i : 3));
    do_run(3 + HALT_WIN, 1'b1, 1'b0);
  endtask

  task automatic test_host_stall();
    gen_random_pcs();
    do_run(-1, 1'b1, 1'b0);
    host_read(4'($urandom_range(0, 15)));
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_abort_busy: got %b exp 0", busy); end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL idle_abort_done: got %b exp 1", done); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL idle_abort_cpu_rst: got %b exp 1", cpu_rst); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_runs();
    int ab;
    for (int r = 0; r < 8; r++) begin
      gen_random_pcs();
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, MAX_CYCLES - 1) : -1;
      do_run(ab, 1'($urandom_range(0, 1)), 1'b1);
      host_read(4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_rst_mid_run();
    pcs.delete();
    for (int i = 0; i < MAX_CYCLES; i++) pcs.push_back(ADDR_W'(i));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      cpu_pc = pcs[i];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL mrst_cpu_rst: got %b exp 1", cpu_rst); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mrst_done: got %b exp 0", done); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL mrst_timeout: got %b exp 0", timeout); end
    n_cmp++; if (cycles !== 32'd0) begin n_err++; $display("FAIL mrst_cycles: got %0d exp 0", cycles); end
    n_cmp++; if (final_pc !== '0) begin n_err++; $display("FAIL mrst_final_pc: got %h exp 0", final_pc); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL mrst_ram_we: got %b exp 0", ram_we); end
    n_cmp++; if (ram_addr !== '0) begin n_err++; $display("FAIL mrst_ram_addr: got %h exp 0", ram_addr); end
    n_cmp++; if (hif.host_rvalid !== 1'b0) begin n_err++; $display("FAIL mrst_rvalid: got %b exp 0", hif.host_rvalid); end
    @(posedge clk); #1;
    // the controller must be fully usable again afterwards
    gen_random_pcs();
    do_run(-1, 1'b0, 1'b0);
  endtask

  task automatic test_readback();
    for (int a = 0; a < 16; a++) host_read(4'(a));
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
    cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_pc = '0;
    test_reset();
    test_host_rw();
    test_halt_loop();
    test_timeout();
    test_abort_with_halt();
    test_host_stall();
    test_abort_idle();
    test_random_runs();
    test_rst_mid_run();
    test_readback();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL exp_q_drained: got %0d exp 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
